sample_loader: RTL and testbench
================================

# sample_loader

Upstream feeder for the neuron layer. Accepts one Q8.8 word per cycle over a valid/ready stream, assembles N feature words plus one label word into a sample, and presents the sample as a parallel `x` bus and `y_true` to `Neuron_Sigmoid` / `Neuron_ReLU`. The block double-buffers samples so the next sample can stream in while the neuron runs its FP/BP phases on the current one. The consumer releases the current sample with a `consume` pulse, normally driven at the end of the BPO phase from `ArchCTRL`.

## Interface
- N, 30, features per sample; matches the neuron `N`.
- BITS, 16, word width, signed Q8.8.
- CLAMP, 16'h04_00, feature saturation magnitude (+4.0). Used only with `XLOAD_CLAMP_EN`.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- s_valid  in  1  input beat valid.
- s_ready  out  1  loader can accept a beat. Registered.
- s_data  in  BITS  feature or label word.
- s_last  in  1  marks the label beat (beat index N).
- x  out  [N-1:0][BITS-1:0]  active sample features; `x[i]` is beat i.
- y_true  out  BITS  active sample label.
- x_valid  out  1  `x` and `y_true` hold a valid sample.
- consume  in  1  single-cycle pulse; the neuron is done with the active sample.
- err  out  1  sticky framing error.
- sample_cnt  out  16  number of samples committed to the active buffer.

## Operation
- Storage:
  - Shadow buffer: N words plus label, with beat index `idx` in 0..N.
  - Active buffer: drives `x` and `y_true`.
- State machine, two states:
  - FILL: `s_ready`=1. A beat is accepted when `s_valid & s_ready`.
    - `idx` < N: shadow[idx] ← s_data, `idx`++.
    - `idx` == N: label ← s_data, shadow becomes complete, `idx` ← 0.
  - On completion, if the active buffer is empty (or `consume` is asserted that cycle):
    - Transfer shadow → active, `x_valid` ← 1, `sample_cnt`++, remain in FILL.
    - Otherwise go to FULL.
  - FULL: `s_ready`=0. When `x_valid`=0 or `consume`=1, transfer shadow → active, `sample_cnt`++, return to FILL.
- `consume` with no new transfer that cycle: `x_valid` ← 0. The contents of `x` and `y_true` are retained, not cleared.
- `consume` while `x_valid`=0 is ignored.
- Framing errors:
  - `s_last`=1 at `idx` < N (short sample): `err` ← 1, shadow discarded, `idx` ← 0. The beat is consumed; no transfer.
  - `s_last`=0 at `idx` == N (long sample): `err` ← 1, beat consumed, shadow discarded, `idx` ← 0.
- `err` is cleared only by reset.
- `sample_cnt` wraps from 16'hFFFF to 0.
- Arithmetic: none except the optional clamp. Words are stored bit-exact.

## Timing
- Reset values: `s_ready`=0, `x_valid`=0, `x`=0, `y_true`=0, `err`=0, `sample_cnt`=0, state=FILL, `idx`=0.
- `s_ready` rises on the first `clk` edge after `rst_n` deasserts.
- Throughput: 1 beat per cycle; N+1 cycles per sample at full rate.
- Latency: label beat accepted at edge t gives `x_valid`=1 and new `x` visible after edge t. A FULL→FILL transfer at edge t gives `s_ready`=1 after edge t.
- Label accepted on the same edge as `consume`: transfer occurs, `x_valid` stays 1 with no gap, and `x` changes.
- Label accepted while the active buffer is held: `s_ready` is 0 after that edge. No further beat is accepted.
- `x` changes only on transfer edges, so it is stable for the whole FP/BP sequence of a sample.
- Reset asserted mid-sample or in FULL: all state returns to reset values immediately. Partial shadow data is lost.

## Configuration
- `XLOAD_CLAMP_EN` defined: each feature beat is saturated on capture to [−CLAMP, +CLAMP] as a signed compare. The label is never clamped.
- `XLOAD_CLAMP_EN` undefined: features are stored verbatim, and CLAMP has no effect.

## Test plan
- Reset then single sample (N=30): feature beats 16'h01_00…, label 16'h00_00 with `s_last` on beat 30 -> `x_valid`=1 the cycle after the label, `x[0]`=16'h01_00, `y_true`=0, `sample_cnt`=1.
- Back-to-back samples with no `consume` -> second sample fills the shadow, `s_ready`=0 after its label, `x` still holds sample 1. `consume` pulse -> next edge `x` = sample 2, `s_ready`=1, `sample_cnt`=2.
- `consume` on the same edge as the sample-2 label -> `x_valid` never drops, `x` switches to sample 2.
- `s_last`=1 on beat 5 -> `err`=1, no transfer, next 31 clean beats load normally. `s_last`=0 on beat 30 -> `err`=1, shadow discarded.
- With `XLOAD_CLAMP_EN`: features 16'hFE_EF, 16'h05_00, 16'hF8_00 -> stored as 16'hFE_EF, 16'h04_00, 16'hFC_00. Label 16'h05_00 is unchanged. Without the macro, all values are stored unchanged.
- `rst_n` low on beat 12 -> all outputs return to reset values asynchronously. After release, a full clean sample loads correctly.

Source files
------------

// File: rtl/sample_loader.sv
// ---------------------------------------------------------------------------
// sample_loader
//
// Double-buffered sample assembler feeding the neuron layer. Q8.8 words
// arrive one per cycle on a valid/ready stream: N feature beats followed by
// one label beat (flagged with s_last). A completed sample is held in a
// shadow buffer until the active buffer is free. The shadow is then copied
// to the active buffer, which drives the parallel x / y_true bus. The
// consumer frees the active buffer with a single-cycle consume pulse.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   s_valid     input beat valid
//   s_ready     loader can accept a beat (registered)
//   s_data      feature or label word (signed Q8.8)
//   s_last      marks the label beat (beat index N)
//   x           active sample features, x[i] is beat i
//   y_true      active sample label
//   x_valid     x / y_true hold a valid sample
//   consume     single-cycle release of the active sample
//   err         sticky framing error (short or long sample)
//   sample_cnt  samples committed to the active buffer (wraps)
//
// Build option:
//   XLOAD_CLAMP_EN  when defined, feature beats are saturated on capture to
//                   [-CLAMP, +CLAMP] (signed). The label is never clamped.
// ---------------------------------------------------------------------------
module sample_loader #(
    parameter int                N     = 30,
    parameter int                BITS  = 16,
    parameter logic [BITS-1:0]   CLAMP = 16'h04_00
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [BITS-1:0]           s_data,
    input  logic                      s_last,
    output logic [N-1:0][BITS-1:0]    x,
    output logic [BITS-1:0]           y_true,
    output logic                      x_valid,
    input  logic                      consume,
    output logic                      err,
    output logic [15:0]               sample_cnt
);

    localparam int                IDX_W    = $clog2(N + 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(N);

    localparam logic [0:0] ST_FILL = 1'b0;
    localparam logic [0:0] ST_FULL = 1'b1;

`ifdef XLOAD_CLAMP_EN
    localparam bit CLAMP_ON = 1'b1;
`else
    localparam bit CLAMP_ON = 1'b0;
`endif

    // Signed saturation of a feature word to [-CLAMP, +CLAMP].
    function automatic logic [BITS-1:0] sat_feature(input logic [BITS-1:0] w);
        logic signed [BITS-1:0] v;
        logic signed [BITS-1:0] hi;
        logic signed [BITS-1:0] lo;
        v  = signed'(w);
        hi = signed'(CLAMP);
        lo = -hi;
        if (CLAMP_ON && (v > hi)) begin
            return hi;
        end else if (CLAMP_ON && (v < lo)) begin
            return lo;
        end
        return w;
    endfunction

    logic [0:0]                 state_q,    state_d;
    logic [IDX_W-1:0]           idx_q,      idx_d;
    logic [N-1:0][BITS-1:0]     shadow_x_q, shadow_x_d;
    logic [BITS-1:0]            shadow_y_q, shadow_y_d;
    logic [N-1:0][BITS-1:0]     act_x_q,    act_x_d;
    logic [BITS-1:0]            act_y_q,    act_y_d;
    logic                       x_valid_q,  x_valid_d;
    logic                       s_ready_q,  s_ready_d;
    logic                       err_q,      err_d;
    logic [15:0]                cnt_q,      cnt_d;

    logic                       accept;
    logic                       xfer;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        shadow_x_d = shadow_x_q;
        shadow_y_d = shadow_y_q;
        act_x_d    = act_x_q;
        act_y_d    = act_y_q;
        x_valid_d  = x_valid_q;
        err_d      = err_q;
        cnt_d      = cnt_q;
        xfer       = 1'b0;
        accept     = s_valid & s_ready_q;

        case (state_q)
            ST_FILL: begin
                if (accept) begin
                    if (idx_q != IDX_LAST) begin
                        if (s_last) begin
                            // Short sample: drop the partial shadow.
                            err_d = 1'b1;
                            idx_d = '0;
                        end else begin
                            shadow_x_d[idx_q] = sat_feature(s_data);
                            idx_d             = idx_q + IDX_W'(1);
                        end
                    end else begin
                        idx_d = '0;
                        if (!s_last) begin
                            // Long sample: the extra beat is swallowed.
                            err_d = 1'b1;
                        end else if (!x_valid_q || consume) begin
                            // Label goes straight to the active side; it
                            // never needs to land in the shadow first.
                            act_x_d = shadow_x_q;
                            act_y_d = s_data;
                            xfer    = 1'b1;
                        end else begin
                            shadow_y_d = s_data;
                            state_d    = ST_FULL;
                        end
                    end
                end
            end
            ST_FULL: begin
                if (!x_valid_q || consume) begin
                    act_x_d = shadow_x_q;
                    act_y_d = shadow_y_q;
                    xfer    = 1'b1;
                    state_d = ST_FILL;
                end
            end
            default: begin
                state_d = ST_FILL;
            end
        endcase

        if (xfer) begin
            x_valid_d = 1'b1;
            cnt_d     = cnt_q + 16'd1;
        end else if (consume) begin
            x_valid_d = 1'b0;
        end

        // Ready is registered, so it looks at where the FSM is heading.
        s_ready_d = (state_d == ST_FILL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_FILL;
            idx_q      <= '0;
            shadow_x_q <= '0;
            shadow_y_q <= '0;
            act_x_q    <= '0;
            act_y_q    <= '0;
            x_valid_q  <= 1'b0;
            s_ready_q  <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            shadow_x_q <= shadow_x_d;
            shadow_y_q <= shadow_y_d;
            act_x_q    <= act_x_d;
            act_y_q    <= act_y_d;
            x_valid_q  <= x_valid_d;
            s_ready_q  <= s_ready_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
        end
    end

    assign s_ready    = s_ready_q;
    assign x          = act_x_q;
    assign y_true     = act_y_q;
    assign x_valid    = x_valid_q;
    assign err        = err_q;
    assign sample_cnt = cnt_q;

endmodule

// File: tb/tb_sample_loader.sv
module tb_sample_loader;

    localparam int N    = 30;
    localparam int BITS = 16;
    localparam int LIM  = 1024;   // +4.0 in Q8.8

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   s_valid = 1'b0;
    logic                   s_ready;
    logic [BITS-1:0]        s_data = '0;
    logic                   s_last = 1'b0;
    logic [N-1:0][BITS-1:0] x;
    logic [BITS-1:0]        y_true;
    logic                   x_valid;
    logic                   consume = 1'b0;
    logic                   err;
    logic [15:0]            sample_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    sample_loader #(.N(N), .BITS(BITS), .CLAMP(16'h04_00)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_last     (s_last),
        .x          (x),
        .y_true     (y_true),
        .x_valid    (x_valid),
        .consume    (consume),
        .err        (err),
        .sample_cnt (sample_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    function automatic logic [15:0] cap(input logic [15:0] w);
`ifdef XLOAD_CLAMP_EN
        int v;
        v = int'($signed(w));
        if (v > LIM)  return 16'(LIM);
        if (v < -LIM) return 16'(-LIM);
`endif
        return w;
    endfunction

    logic [15:0]            fill_q[$];
    logic [15:0]            pend_q[$];
    logic [15:0]            pend_y;
    bit                     pend;
    logic [N-1:0][15:0]     m_x;
    logic [15:0]            m_y;
    bit                     m_xv, m_rdy, m_err;
    logic [15:0]            m_cnt;
    bit                     m_acc;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_q.delete();
            pend_q.delete();
            pend   = 0;
            pend_y = '0;
            m_x    = '0;
            m_y    = '0;
            m_xv   = 0;
            m_rdy  = 0;
            m_err  = 0;
            m_cnt  = '0;
        end else begin
            m_acc = s_valid && m_rdy;
            if (m_acc) begin
                if (!s_last) begin
                    if (fill_q.size() == N) begin
                        m_err = 1;
                        fill_q.delete();
                    end else begin
                        fill_q.push_back(cap(s_data));
                    end
                end else begin
                    if (fill_q.size() != N) begin
                        m_err = 1;
                    end else begin
                        pend_q = fill_q;
                        pend_y = s_data;
                        pend   = 1;
                    end
                    fill_q.delete();
                end
            end
            if (pend && (!m_xv || consume)) begin
                for (int i = 0; i < N; i++) m_x[i] = pend_q[i];
                m_y   = pend_y;
                m_xv  = 1;
                m_cnt = m_cnt + 16'd1;
                pend  = 0;
            end else if (consume) begin
                m_xv = 0;
            end
            m_rdy = !pend;
        end
    end

    always @(negedge clk) begin
        chk("s_ready",    s_ready,    m_rdy);
        chk("x_valid",    x_valid,    m_xv);
        chk("err",        err,        m_err);
        chk("sample_cnt", sample_cnt, m_cnt);
        chk("y_true",     y_true,     m_y);
        chk("x_bus",      x,          m_x);
    end

    // ---------------- stimulus ----------------
    // All tasks start and end just after a falling edge.
    task automatic beat(input logic [15:0] d, input logic l, input logic c);
        int t;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        consume = c;
        t = 0;
        while (!s_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            n_chk++;
            n_fail++;
            $display("FAIL beat_timeout: s_ready stuck low, data %0h", d);
        end
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
        consume = 1'b0;
    endtask

    task automatic send_sample(input logic [15:0] base, input logic [15:0] lbl, input logic c);
        for (int i = 0; i < N; i++) beat(base + 16'(i), 1'b0, 1'b0);
        beat(lbl, 1'b1, c);
    endtask

    task automatic pulse_consume();
        consume = 1'b1;
        @(negedge clk);
        consume = 1'b0;
    endtask

    initial begin
        int bidx;
        bit acc;

        repeat (2) @(negedge clk);
        chk("rst_s_ready", s_ready, 1'b0);
        chk("rst_x_valid", x_valid, 1'b0);
        chk("rst_cnt", sample_cnt, 16'd0);
        chk("rst_x", x, '0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", s_ready, 1'b1);

        // single sample
        send_sample(16'h0100, 16'h0000, 1'b0);
        chk("s1_x_valid", x_valid, 1'b1);
        chk("s1_x0", x[0], 16'h0100);
        chk("s1_x29", x[29], 16'h011D);
        chk("s1_y", y_true, 16'h0000);
        chk("s1_cnt", sample_cnt, 16'd1);

        // second sample parks in the shadow
        send_sample(16'h0200, 16'h0022, 1'b0);
        chk("s2_ready_low", s_ready, 1'b0);
        chk("s2_x0_held", x[0], 16'h0100);
        chk("s2_cnt_held", sample_cnt, 16'd1);
        pulse_consume();
        chk("s2_x0", x[0], 16'h0200);
        chk("s2_y", y_true, 16'h0022);
        chk("s2_ready", s_ready, 1'b1);
        chk("s2_cnt", sample_cnt, 16'd2);

        // consume on the label edge
        send_sample(16'h0300, 16'h0033, 1'b1);
        chk("s3_x_valid", x_valid, 1'b1);
        chk("s3_x0", x[0], 16'h0300);
        chk("s3_cnt", sample_cnt, 16'd3);

        // short sample: s_last on beat 5
        for (int i = 0; i < 4; i++) beat(16'h0AA0 + 16'(i), 1'b0, 1'b0);
        beat(16'h0AA4, 1'b1, 1'b0);
        chk("short_err", err, 1'b1);
        chk("short_cnt", sample_cnt, 16'd3);
        chk("short_x0", x[0], 16'h0300);
        send_sample(16'h0400, 16'h0044, 1'b0);
        chk("d_ready_low", s_ready, 1'b0);
        pulse_consume();
        chk("d_x0", x[0], 16'h0400);
        chk("d_cnt", sample_cnt, 16'd4);

        // long sample: no s_last on beat 30
        send_sample(16'h0BB0, 16'h0BBB, 1'b0);
        // that label (s_last) landed after an already-full count; redo as true long:
        // the sample above completed normally into the shadow only if idx aligned.
        pulse_consume();
        for (int i = 0; i < N; i++) beat(16'h0C00 + 16'(i), 1'b0, 1'b0);
        beat(16'h0CCC, 1'b0, 1'b0);
        chk("long_err", err, 1'b1);
        chk("long_ready", s_ready, 1'b1);
        chk("long_cnt", sample_cnt, 16'd5);
        chk("long_x0", x[0], 16'h0BB0);

        // clamp sample
        pulse_consume();
        chk("consumed_x_valid", x_valid, 1'b0);
        chk("consumed_x_kept", x[0], 16'h0BB0);
        beat(16'hFEEF, 1'b0, 1'b0);
        beat(16'h0500, 1'b0, 1'b0);
        beat(16'hF800, 1'b0, 1'b0);
        for (int i = 3; i < N; i++) beat(16'(i * 16), 1'b0, 1'b0);
        beat(16'h0500, 1'b1, 1'b0);
        chk("e_cnt", sample_cnt, 16'd6);
        chk("e_x0", x[0], 16'hFEEF);
`ifdef XLOAD_CLAMP_EN
        chk("e_x1_clamped", x[1], 16'h0400);
        chk("e_x2_clamped", x[2], 16'hFC00);
`else
        chk("e_x1", x[1], 16'h0500);
        chk("e_x2", x[2], 16'hF800);
`endif
        chk("e_label", y_true, 16'h0500);

        // reset in the middle of a sample (beat 12)
        for (int i = 0; i < 11; i++) beat(16'h0D00 + 16'(i), 1'b0, 1'b0);
        s_valid = 1'b1;
        s_data  = 16'h0D0B;
        #2 rst_n = 1'b0;
        #1;
        chk("ar_x_valid", x_valid, 1'b0);
        chk("ar_s_ready", s_ready, 1'b0);
        chk("ar_err", err, 1'b0);
        chk("ar_cnt", sample_cnt, 16'd0);
        chk("ar_x", x, '0);
        chk("ar_y", y_true, 16'h0000);
        @(negedge clk);
        s_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_sample(16'h0600, 16'h0066, 1'b0);
        chk("f_cnt", sample_cnt, 16'd1);
        chk("f_x0", x[0], 16'h0600);
        chk("f_x10", x[10], 16'h060A);
        chk("f_y", y_true, 16'h0066);

        // randomized traffic, occasional framing errors
        bidx = 0;
        for (int c = 0; c < 3000; c++) begin
            s_valid = ($urandom_range(0, 3) != 0);
            s_data  = 16'($urandom);
            s_last  = (bidx == N);
            if ($urandom_range(0, 59) == 0) s_last = !s_last;
            consume = ($urandom_range(0, 15) == 0);
            acc = s_valid && s_ready;
            if (acc) begin
                if (bidx == N || s_last) bidx = 0;
                else bidx++;
            end
            @(negedge clk);
        end
        s_valid = 1'b0;
        consume = 1'b0;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
